// File: rtl/seq_mantissa_multiplier_pkg.sv
// rtl/seq_mantissa_multiplier_pkg.sv - shared states, rounding modes and size helpers
package mant_mul_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_MUL   = 2'd1;
   localparam state_t ST_ROUND = 2'd2;
   localparam state_t ST_DONE  = 2'd3;

   localparam logic RND_TRUNC = 1'b0;
   localparam logic RND_RNE   = 1'b1;

   function automatic int iter_count(input int mant_width, input int bits_per_cycle);
      return (mant_width + 1) / bits_per_cycle;
   endfunction

   function automatic int prod_width(input int mant_width);
      return 2 * mant_width + 2;
   endfunction

endpackage

// File: rtl/seq_mantissa_multiplier_if.sv
// rtl/seq_mantissa_multiplier_if.sv - operand/result handshake bundle of the mantissa multiplier
interface seq_mantissa_multiplier_if #(
   parameter int MANT_WIDTH = 23
);
   logic                  in_valid;
   logic                  in_ready;
   logic [MANT_WIDTH-1:0] in0;
   logic [MANT_WIDTH-1:0] in1;
   logic                  in0_zero;
   logic                  in1_zero;
   logic                  rnd_mode;
   logic                  out_valid;
   logic                  out_ready;
   logic [MANT_WIDTH-1:0] out;
   logic [1:0]            exp_inc;
   logic                  out_zero;

   modport master (
      output in_valid, in0, in1, in0_zero, in1_zero, rnd_mode, out_ready,
      input  in_ready, out_valid, out, exp_inc, out_zero
   );

   modport slave (
      input  in_valid, in0, in1, in0_zero, in1_zero, rnd_mode, out_ready,
      output in_ready, out_valid, out, exp_inc, out_zero
   );
endinterface

// File: rtl/seq_mantissa_multiplier_round.sv
// rtl/seq_mantissa_multiplier_round.sv - combinational normalise and round of a significand product
module mant_round_unit
   import mant_mul_pkg::*;
#(
   parameter int MANT_WIDTH = 23
) (
   input  logic [2*MANT_WIDTH+1:0] prod,
   input  logic                    rnd_mode,
   output logic [MANT_WIDTH-1:0]   frac,
   output logic [1:0]              exp_inc
);
   localparam int W = MANT_WIDTH;

   logic         norm;
   logic         guard;
   logic         sticky;
   logic         round_up;
   logic [W-1:0] frac_raw;
   logic [W:0]   frac_sum;

   always_comb begin
      norm = prod[2*W+1];
      if (norm) begin
         frac_raw = prod[2*W:W+1];
         guard    = prod[W];
         sticky   = |prod[W-1:0];
      end else begin
         frac_raw = prod[2*W-1:W];
         guard    = prod[W-1];
         sticky   = |prod[W-2:0];
      end
      round_up = (rnd_mode == RND_RNE) && guard && (sticky || frac_raw[0]);
      // A carry out of the fraction leaves it all-zero and bumps the exponent once more
      frac_sum = {1'b0, frac_raw} + {{W{1'b0}}, round_up};
      frac     = frac_sum[W-1:0];
      exp_inc  = {1'b0, norm} + {1'b0, frac_sum[W]};
   end
endmodule

// File: rtl/seq_mantissa_multiplier.sv
// rtl/seq_mantissa_multiplier.sv - multi-cycle shift-add significand multiplier with normalise/round
module seq_mantissa_multiplier
   import mant_mul_pkg::*;
#(
   parameter int MANT_WIDTH     = 23,
   parameter int BITS_PER_CYCLE = 1
) (
   input logic                    clk,
   input logic                    rst_n,
   seq_mantissa_multiplier_if.slave bus
);
   localparam int W    = MANT_WIDTH;
   localparam int SW   = W + 1;
   localparam int BPC  = BITS_PER_CYCLE;
   localparam int PW   = prod_width(W);
   localparam int ITER = iter_count(W, BPC);
   localparam int CW   = $clog2(ITER + 1);
   localparam logic [CW-1:0] LAST = CW'(ITER - 1);

   generate
      if (SW % BPC != 0) begin : g_bad_bpc
         $error("BITS_PER_CYCLE must divide MANT_WIDTH+1");
      end
   endgenerate

   state_t          state;
   logic [PW-1:0]   acc;
   logic [CW-1:0]   cnt;
   logic [SW-1:0]   mcand;
   logic            rnd_q;
   logic [W-1:0]    out_q;
   logic [1:0]      exp_inc_q;
   logic            zero_q;
   logic [W-1:0]    rnd_frac;
   logic [1:0]      rnd_exp_inc;
   logic [SW+BPC-1:0] partial;
   logic [PW-1:0]   acc_next;

   mant_round_unit #(.MANT_WIDTH(W)) u_round (
      .prod    (acc),
      .rnd_mode(rnd_q),
      .frac    (rnd_frac),
      .exp_inc (rnd_exp_inc)
   );

   // Upper half gathers partial products; the multiplier drains out of the lower half
   always_comb begin
      partial  = {{BPC{1'b0}}, acc[PW-1:SW]}
               + ({{BPC{1'b0}}, mcand} * {{SW{1'b0}}, acc[BPC-1:0]});
      acc_next = {partial, acc[SW-1:BPC]};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         acc       <= '0;
         cnt       <= '0;
         mcand     <= '0;
         rnd_q     <= RND_TRUNC;
         out_q     <= '0;
         exp_inc_q <= '0;
         zero_q    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (bus.in_valid) begin
                  mcand <= {1'b1, bus.in0};
                  rnd_q <= bus.rnd_mode;
                  cnt   <= '0;
                  if (bus.in0_zero || bus.in1_zero) begin
                     out_q     <= '0;
                     exp_inc_q <= '0;
                     zero_q    <= 1'b1;
                     state     <= ST_DONE;
                  end else begin
                     acc   <= {{SW{1'b0}}, 1'b1, bus.in1};
                     state <= ST_MUL;
                  end
               end
            end
            ST_MUL: begin
               acc <= acc_next;
               cnt <= cnt + CW'(1);
               if (cnt == LAST) state <= ST_ROUND;
            end
            ST_ROUND: begin
               out_q     <= rnd_frac;
               exp_inc_q <= rnd_exp_inc;
               zero_q    <= 1'b0;
               state     <= ST_DONE;
            end
            ST_DONE: begin
               if (bus.out_ready) state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = (state == ST_IDLE);
   assign bus.out_valid = (state == ST_DONE);
   assign bus.out       = out_q;
   assign bus.exp_inc   = exp_inc_q;
   assign bus.out_zero  = zero_q;
endmodule

// File: tb/tb_seq_mantissa_multiplier.sv
// tb/tb_seq_mantissa_multiplier.sv - randomized bench for two multiplier configurations
module tb_seq_mantissa_multiplier;
   localparam int W = 23;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n       [2];
   logic         in_valid_d  [2];
   logic         in0_zero_d  [2];
   logic         in1_zero_d  [2];
   logic         rnd_d       [2];
   logic         out_ready_d [2];
   logic [W-1:0] in0_d       [2];
   logic [W-1:0] in1_d       [2];
   logic         in_ready_o  [2];
   logic         out_valid_o [2];
   logic         out_zero_o  [2];
   logic [W-1:0] out_o       [2];
   logic [1:0]   exp_inc_o   [2];

   int total = 0;
   int bad   = 0;

   seq_mantissa_multiplier_if #(.MANT_WIDTH(W)) bus_a ();
   seq_mantissa_multiplier_if #(.MANT_WIDTH(W)) bus_b ();

   assign bus_a.in_valid  = in_valid_d[0];
   assign bus_a.in0       = in0_d[0];
   assign bus_a.in1       = in1_d[0];
   assign bus_a.in0_zero  = in0_zero_d[0];
   assign bus_a.in1_zero  = in1_zero_d[0];
   assign bus_a.rnd_mode  = rnd_d[0];
   assign bus_a.out_ready = out_ready_d[0];
   assign in_ready_o[0]   = bus_a.in_ready;
   assign out_valid_o[0]  = bus_a.out_valid;
   assign out_o[0]        = bus_a.out;
   assign exp_inc_o[0]    = bus_a.exp_inc;
   assign out_zero_o[0]   = bus_a.out_zero;

   assign bus_b.in_valid  = in_valid_d[1];
   assign bus_b.in0       = in0_d[1];
   assign bus_b.in1       = in1_d[1];
   assign bus_b.in0_zero  = in0_zero_d[1];
   assign bus_b.in1_zero  = in1_zero_d[1];
   assign bus_b.rnd_mode  = rnd_d[1];
   assign bus_b.out_ready = out_ready_d[1];
   assign in_ready_o[1]   = bus_b.in_ready;
   assign out_valid_o[1]  = bus_b.out_valid;
   assign out_o[1]        = bus_b.out;
   assign exp_inc_o[1]    = bus_b.exp_inc;
   assign out_zero_o[1]   = bus_b.out_zero;

   seq_mantissa_multiplier #(.MANT_WIDTH(W), .BITS_PER_CYCLE(1)) u_dut1 (
      .clk  (clk),
      .rst_n(rst_n[0]),
      .bus  (bus_a)
   );

   seq_mantissa_multiplier #(.MANT_WIDTH(W), .BITS_PER_CYCLE(4)) u_dut4 (
      .clk  (clk),
      .rst_n(rst_n[1]),
      .bus  (bus_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, want, $time);
      end
   endtask

   // Reference: exact integer product, then scale and round as real-valued arithmetic
   task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic za, input logic zb, input logic rm,
                        output logic [W-1:0] f, output logic [1:0] e, output logic z);
      longint unsigned ma, mb, p, q, rem, half;
      int sh;
      if (za || zb) begin
         f = '0; e = 2'd0; z = 1'b1;
         return;
      end
      ma = 64'(a) + (64'd1 << W);
      mb = 64'(b) + (64'd1 << W);
      p  = ma * mb;
      sh = (p >= (64'd1 << (2 * W + 1))) ? W + 1 : W;
      e  = (sh == W + 1) ? 2'd1 : 2'd0;
      q    = p >> sh;
      rem  = p & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      if (rm && (rem > half || (rem == half && q[0]))) q = q + 1;
      if (q == (64'd1 << (W + 1))) begin
         q = q >> 1;
         e = e + 2'd1;
      end
      f = q[W-1:0];
      z = 1'b0;
   endtask

   task automatic check_reset_outputs(input int s, input string tag);
      check({tag, "_out_valid"}, 32'(out_valid_o[s]), 32'd0);
      check({tag, "_out"},       32'(out_o[s]),       32'd0);
      check({tag, "_exp_inc"},   32'(exp_inc_o[s]),   32'd0);
      check({tag, "_out_zero"},  32'(out_zero_o[s]),  32'd0);
      check({tag, "_in_ready"},  32'(in_ready_o[s]),  32'd1);
   endtask

   // Starts and ends on a falling edge
   task automatic run_op(input int s, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic za, input logic zb, input logic rm, input int hold);
      logic [W-1:0] ef;
      logic [1:0]   ee;
      logic         ez;
      int           n;
      int           lat;
      model(a, b, za, zb, rm, ef, ee, ez);
      lat = (za || zb) ? 1 : ((s == 0) ? 26 : 8);
      n = 0;
      while (!in_ready_o[s] && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("in_ready_before", 32'(in_ready_o[s]), 32'd1);
      in0_d[s] = a; in1_d[s] = b;
      in0_zero_d[s] = za; in1_zero_d[s] = zb;
      rnd_d[s] = rm;
      in_valid_d[s] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid_d[s] = 1'b0;
      n = 1;
      check("busy_in_ready", 32'(in_ready_o[s]), 32'd0);
      while (!out_valid_o[s] && n < lat + 10) begin
         @(negedge clk);
         n++;
      end
      check("latency", 32'(n), 32'(lat));
      check("out", 32'(out_o[s]), 32'(ef));
      check("exp_inc", 32'(exp_inc_o[s]), 32'(ee));
      check("out_zero", 32'(out_zero_o[s]), 32'(ez));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("hold_out_valid", 32'(out_valid_o[s]), 32'd1);
         check("hold_out", 32'(out_o[s]), 32'(ef));
         check("hold_exp_inc", 32'(exp_inc_o[s]), 32'(ee));
         check("hold_in_ready", 32'(in_ready_o[s]), 32'd0);
      end
      out_ready_d[s] = 1'b1;
      @(negedge clk);
      out_ready_d[s] = 1'b0;
      check("idle_out_valid", 32'(out_valid_o[s]), 32'd0);
      check("idle_in_ready", 32'(in_ready_o[s]), 32'd1);
   endtask

   task automatic run_random(input int s, input int count);
      logic [W-1:0] a, b;
      for (int i = 0; i < count; i++) begin
         a = W'($urandom);
         b = W'($urandom);
         case ($urandom_range(0, 7))
            0: a = '0;
            1: b = {W{1'b1}};
            default: ;
         endcase
         run_op(s, a, b, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0,
                1'($urandom_range(0, 1)), $urandom_range(0, 2));
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int stray;
      for (int s = 0; s < 2; s++) begin
         rst_n[s] = 1'b0;
         in_valid_d[s] = 1'b0; in0_zero_d[s] = 1'b0; in1_zero_d[s] = 1'b0;
         rnd_d[s] = 1'b0; out_ready_d[s] = 1'b0;
         in0_d[s] = '0; in1_d[s] = '0;
      end
      repeat (3) @(negedge clk);
      check_reset_outputs(0, "rst_a");
      check_reset_outputs(1, "rst_b");
      rst_n[0] = 1'b1;
      rst_n[1] = 1'b1;
      @(negedge clk);

      run_op(0, 23'h400000, 23'h400000, 1'b0, 1'b0, 1'b1, 0);
      run_op(0, 23'h400000, 23'h000001, 1'b0, 1'b0, 1'b1, 0);
      run_op(0, 23'h400000, 23'h000001, 1'b0, 1'b0, 1'b0, 0);
      run_op(0, 23'h000001, 23'h000001, 1'b0, 1'b0, 1'b1, 0);
      run_op(0, 23'h7FFFFF, 23'h7FFFFF, 1'b0, 1'b0, 1'b1, 10);
      run_op(0, 23'h123456, 23'h123456, 1'b1, 1'b0, 1'b1, 0);
      run_op(0, 23'h000000, 23'h000000, 1'b0, 1'b0, 1'b1, 0);
      run_op(0, 23'h7FFFFF, 23'h654321, 1'b0, 1'b1, 1'b0, 3);
      run_random(0, 40);

      run_op(1, 23'h400000, 23'h400000, 1'b0, 1'b0, 1'b1, 0);

      in0_d[1] = 23'h400000; in1_d[1] = 23'h400000;
      in0_zero_d[1] = 1'b0; in1_zero_d[1] = 1'b0; rnd_d[1] = 1'b1;
      in_valid_d[1] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid_d[1] = 1'b0;
      repeat (3) @(negedge clk);
      rst_n[1] = 1'b0;
      #1;
      check_reset_outputs(1, "abort");
      @(negedge clk);
      rst_n[1] = 1'b1;
      stray = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (out_valid_o[1]) stray++;
      end
      check("abort_no_result", 32'(stray), 32'd0);

      run_op(1, 23'h000001, 23'h000001, 1'b0, 1'b0, 1'b1, 0);
      run_op(1, 23'h7FFFFF, 23'h7FFFFF, 1'b0, 1'b0, 1'b1, 2);
      run_op(1, 23'h123456, 23'h123456, 1'b0, 1'b1, 1'b0, 0);
      run_random(1, 25);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/seq_mantissa_multiplier.md
# seq_mantissa_multiplier

Multi-cycle, parametrised shift-add multiplier for floating-point significands, built as the successor of the combinational mantissa multiplier in the FP multiplier datapath. It multiplies two implicit-one significands in a configurable number of bits per cycle. It normalises the product and rounds it by a selectable mode (truncate or round-to-nearest-even). It reports the exponent increment to the exponent adder and uses valid/ready handshakes on both sides, so it can sit between the unpack and pack stages of a pipelined multiplier.

## Interface
- MANT_WIDTH, 23, stored fraction bits; significand is {1'b1, frac}, width MANT_WIDTH+1.
- BITS_PER_CYCLE, 1, multiplier bits consumed per MUL cycle; must divide MANT_WIDTH+1 (elaboration error otherwise).
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept; high only in IDLE.
- in0, in1  in  MANT_WIDTH  fraction fields (hidden 1 implied).
- in0_zero, in1_zero  in  1  operand is ±0 (decided by exponent logic, not by fraction value).
- rnd_mode  in  1  0 = truncate toward zero, 1 = RNE; sampled at acceptance.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out  out  MANT_WIDTH  rounded, normalised fraction (hidden 1 dropped).
- exp_inc  out  2  amount to add to the exponent sum: 0, 1 or 2.
- out_zero  out  1  result is zero.

## Operation
- FSM states: IDLE, MUL, ROUND, DONE.
- IDLE: in_valid&in_ready latches the operands, the zero flags and rnd_mode.
  - Either zero flag set: go to DONE with out=0, exp_inc=0, out_zero=1.
  - Otherwise: load the accumulator (2·MANT_WIDTH+2 bits), clear the iteration counter, go to MUL.
- MUL: each cycle add {1,in0}·(low BITS_PER_CYCLE bits of multiplier) to the upper half, then shift right by BITS_PER_CYCLE. After ITER=(MANT_WIDTH+1)/BITS_PER_CYCLE cycles, go to ROUND.
- ROUND: product P (width 2W+2, W=MANT_WIDTH). The rounded result is registered; next state is DONE.
  - Normalisation when P[2W+1]=1: norm=1; frac=P[2W:W+1], guard=P[W], sticky=|P[W-1:0].
  - Normalisation otherwise: norm=0; frac=P[2W-1:W], guard=P[W-1], sticky=|P[W-2:0].
  - RNE rounds up iff guard & (sticky | frac[0]). Truncate never rounds up.
  - Carry out of frac+1 gives frac=0 and exp_inc=norm+1; otherwise exp_inc=norm.
- DONE: out_valid=1. Outputs stay stable while out_ready=0. out_valid&out_ready returns to IDLE.
- An input is never accepted in the same cycle a result is accepted.

## Timing
- Reset values: state IDLE, out_valid=0, out=0, exp_inc=0, out_zero=0, accumulator and counter 0. in_ready=1 once rst_n is high.
- Latency from the acceptance edge to out_valid high:
  - Non-zero operands: ITER+2 cycles (26 for defaults).
  - Zero operand: 1 cycle.
- Throughput: one operation per ITER+3 cycles at best (ITER+2 latency plus the DONE→IDLE cycle).
- rst_n low mid-operation: immediate return to reset values. The in-flight operation is discarded with no partial result.
- in_valid while busy: ignored (in_ready=0). The source must hold it.

## Structure
- Package mant_mul_pkg: state enum, RND_TRUNC/RND_RNE constants, ITER and product-width helper functions.
- Sub-module mant_round_unit: combinational normalise + round (P, rnd_mode → frac, exp_inc). Reused by the adder path later.

## Test plan
- W=23, BPC=1, RNE: in0=in1=0x400000 (1.5×1.5) → out=0x100000, exp_inc=1, out_valid exactly 26 cycles after acceptance.
- Tie rounding with in0=0x400000, in1=0x000001 → RNE gives out=0x400002, truncate gives out=0x400001; exp_inc=0 for both.
- in0=in1=0x000001, RNE → out=0x000002, exp_inc=0. in0=in1=0x7FFFFF → out=0x7FFFFE, exp_inc=1.
- Zero flag: in0_zero=1, in0=in1=0x123456 → out=0, out_zero=1, out_valid 1 cycle after acceptance. Also check that fraction 0 with no zero flag gives 1.0×1.0 → out=0, exp_inc=0, out_zero=0.
- Back-pressure and handshake: hold out_ready=0 for 10 cycles → out, exp_inc and out_valid remain stable, and in_ready stays 0. Then assert out_ready → IDLE on the next cycle.
- BITS_PER_CYCLE=4: 1.5×1.5 gives the same result with latency 8. Pulse rst_n low during MUL → all outputs at reset values, and the next operation is correct.
